// File: rtl/ps2_ascii_if.sv
// Bundle between the PS/2 key-code source, the ASCII decoder and its character consumer.
// master = decoder side, slave = source/consumer side.
interface ps2_ascii_if #(
    parameter int DEPTH = 8
);
    logic [8:0]              key_code;
    logic                    kc_valid;
    // Character handshake: the head transfers on any clk edge where ascii_valid
    // and ascii_ready are both 1. While ascii_valid is 1, ascii_data holds steady
    // until the transfer. ascii_ready may stay high, and may change at any time.
    logic [7:0]              ascii_data;
    logic                    ascii_valid;
    logic                    ascii_ready;
    logic [$clog2(DEPTH):0]  fifo_count;
    logic                    overflow;
    logic                    caps_lock;

    modport master (
        input  key_code, kc_valid, ascii_ready,
        output ascii_data, ascii_valid, fifo_count, overflow, caps_lock
    );

    modport slave (
        output key_code, kc_valid, ascii_ready,
        input  ascii_data, ascii_valid, fifo_count, overflow, caps_lock
    );
endinterface

// File: rtl/ps2_ascii_decoder.sv
// PS/2 key codes to ASCII: modifier tracking, US-layout translation,
// and a small character FIFO with a valid/ready output.
module ps2_ascii_decoder #(
    parameter int DEPTH = 8
) (
    input  logic           clk,
    input  logic           reset,
    ps2_ascii_if.master    bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic       released, extended;
    logic [6:0] code;
    assign released = bus.key_code[8];
    assign extended = bus.key_code[7];
    assign code     = bus.key_code[6:0];

    logic lshift, rshift, lctrl, rctrl, caps;
    logic shift, ctrl;
    assign shift = lshift | rshift;
    assign ctrl  = lctrl | rctrl;

    // Translation table: lowercase / unshifted form of each mapped key.
    logic [7:0] base;
    always_comb begin
        base = 8'h00;
        case (code)
            7'h1C: base = "a";  7'h32: base = "b";  7'h21: base = "c";  7'h23: base = "d";
            7'h24: base = "e";  7'h2B: base = "f";  7'h34: base = "g";  7'h33: base = "h";
            7'h43: base = "i";  7'h3B: base = "j";  7'h42: base = "k";  7'h4B: base = "l";
            7'h3A: base = "m";  7'h31: base = "n";  7'h44: base = "o";  7'h4D: base = "p";
            7'h15: base = "q";  7'h2D: base = "r";  7'h1B: base = "s";  7'h2C: base = "t";
            7'h3C: base = "u";  7'h2A: base = "v";  7'h1D: base = "w";  7'h22: base = "x";
            7'h35: base = "y";  7'h1A: base = "z";
            7'h45: base = "0";  7'h16: base = "1";  7'h1E: base = "2";  7'h26: base = "3";
            7'h25: base = "4";  7'h2E: base = "5";  7'h36: base = "6";  7'h3D: base = "7";
            7'h3E: base = "8";  7'h46: base = "9";
            7'h29: base = 8'h20;
            7'h5A: base = 8'h0D;
            7'h66: base = 8'h08;
            7'h0D: base = 8'h09;
            7'h76: base = 8'h1B;
            default: base = 8'h00;
        endcase
    end

    logic       is_letter, is_digit, mapped;
    logic [7:0] digit_sym, upper, ch;
    assign is_letter = (base >= "a") && (base <= "z");
    assign is_digit  = (base >= "0") && (base <= "9");
    assign mapped    = (base != 8'h00);
    assign upper     = base & 8'hDF;

    always_comb begin
        digit_sym = base;
        case (base)
            "0": digit_sym = ")";  "1": digit_sym = "!";  "2": digit_sym = "@";
            "3": digit_sym = "#";  "4": digit_sym = "$";  "5": digit_sym = "%";
            "6": digit_sym = "^";  "7": digit_sym = "&";  "8": digit_sym = "*";
            "9": digit_sym = "(";
            default: digit_sym = base;
        endcase
    end

    // Modifier registers are read before this event updates them.
    always_comb begin
        ch = base;
        if (is_letter) begin
            if (ctrl)              ch = upper & 8'h1F;
            else if (shift ^ caps) ch = upper;
            else                   ch = base;
        end else if (is_digit && shift) begin
            ch = digit_sym;
        end
    end

    logic gen;
    assign gen = bus.kc_valid & ~released & ~extended & mapped;

    always_ff @(posedge clk) begin
        if (reset) begin
            lshift <= 1'b0;
            rshift <= 1'b0;
            lctrl  <= 1'b0;
            rctrl  <= 1'b0;
            caps   <= 1'b0;
        end else if (bus.kc_valid) begin
            if (code == 7'h12 && !extended) lshift <= ~released;
            if (code == 7'h59)              rshift <= ~released;
            if (code == 7'h14) begin
                if (extended) rctrl <= ~released;
                else          lctrl <= ~released;
            end
            if (code == 7'h58 && !extended && !released) caps <= ~caps;
        end
    end

    logic       s1_valid;
    logic [7:0] s1_char;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_char  <= 8'h00;
        end else begin
            s1_valid <= gen;
            s1_char  <= ch;
        end
    end

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
    logic [CW-1:0] count;
    logic [7:0]    head;
    logic          ovf;
    logic          pop, full, push_ok;

    assign rd_next = rd_ptr + 1'b1;
    assign pop     = (count != '0) & bus.ascii_ready;
    assign full    = (count == CW'(DEPTH));
    assign push_ok = s1_valid & (~full | pop);

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= s1_char;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= 8'h00;
            ovf    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_next;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (s1_valid && full && !pop) ovf <= 1'b1;
            // Head register follows storage only when the head entry changes.
            if (pop) begin
                if (count > CW'(1))  head <= mem[rd_next];
                else if (push_ok)    head <= s1_char;
            end else if (push_ok && count == '0) begin
                head <= s1_char;
            end
        end
    end

    assign bus.ascii_data  = head;
    assign bus.ascii_valid = (count != '0);
    assign bus.fifo_count  = count;
    assign bus.overflow    = ovf;
    assign bus.caps_lock   = caps;
endmodule

// File: tb/tb_ps2_ascii_decoder.sv
// Directed bench for ps2_ascii_decoder: timing, modifiers, translation,
// FIFO fill/overflow/drain and mid-stream reset.
module tb_ps2_ascii_decoder;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    ps2_ascii_if #(.DEPTH(DEPTH)) bus ();

    ps2_ascii_decoder #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    logic [6:0] letter_codes [10];
    initial begin
        letter_codes = '{7'h1C, 7'h32, 7'h21, 7'h23, 7'h24, 7'h2B, 7'h34, 7'h33, 7'h43, 7'h3B};
    end

    task automatic apply_reset();
        bus.kc_valid    = 1'b0;
        bus.key_code    = 9'h000;
        bus.ascii_ready = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic send_key(input logic [8:0] kc);
        @(posedge clk);
        #1;
        bus.key_code = kc;
        bus.kc_valid = 1'b1;
        @(posedge clk);
        #1 bus.kc_valid = 1'b0;
    endtask

    task automatic expect_char(input logic [7:0] exp, input string name);
        int n = 0;
        @(negedge clk);
        while (bus.ascii_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (bus.ascii_valid !== 1'b1) begin
            fails++;
            $display("FAIL %s: ascii_valid never rose, expected char %h", name, exp);
        end else if (bus.ascii_data !== exp) begin
            fails++;
            $display("FAIL %s: ascii_data=%h expected %h", name, bus.ascii_data, exp);
        end
        bus.ascii_ready = 1'b1;
        @(posedge clk);
        #1 bus.ascii_ready = 1'b0;
    endtask

    task automatic expect_empty(input string name);
        repeat (4) @(negedge clk);
        tests++;
        if (bus.ascii_valid !== 1'b0 || bus.fifo_count !== '0) begin
            fails++;
            $display("FAIL %s: valid=%b count=%0d expected valid=0 count=0",
                     name, bus.ascii_valid, bus.fifo_count);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        tests++;
        if (bus.ascii_valid !== 1'b0 || bus.ascii_data !== 8'h00 || bus.fifo_count !== '0 ||
            bus.overflow !== 1'b0 || bus.caps_lock !== 1'b0) begin
            fails++;
            $display("FAIL reset: valid=%b data=%h count=%0d ovf=%b caps=%b expected 0 00 0 0 0",
                     bus.ascii_valid, bus.ascii_data, bus.fifo_count, bus.overflow, bus.caps_lock);
        end
    endtask

    task automatic test_basic();
        @(posedge clk);
        #1;
        bus.key_code = 9'h01C;
        bus.kc_valid = 1'b1;
        @(posedge clk);
        #1 bus.kc_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (bus.ascii_valid !== 1'b0) begin
            fails++;
            $display("FAIL latency_n1: ascii_valid=%b expected 0", bus.ascii_valid);
        end
        @(negedge clk);
        tests++;
        if (bus.ascii_valid !== 1'b1 || bus.ascii_data !== 8'h61) begin
            fails++;
            $display("FAIL latency_n2: valid=%b data=%h expected 1 61", bus.ascii_valid, bus.ascii_data);
        end
        send_key(9'h11C);
        expect_char(8'h61, "basic_a");
        expect_empty("basic_break_silent");
    endtask

    task automatic test_shift_digits();
        send_key(9'h012);
        send_key(9'h01E);
        send_key(9'h112);
        send_key(9'h01E);
        expect_char(8'h40, "shift_2");
        expect_char(8'h32, "plain_2");
        expect_empty("shift_no_extra");
    endtask

    task automatic test_caps();
        send_key(9'h058);
        send_key(9'h01C);
        send_key(9'h012);
        send_key(9'h015);
        @(negedge clk);
        tests++;
        if (bus.caps_lock !== 1'b1) begin
            fails++;
            $display("FAIL caps_on: caps_lock=%b expected 1", bus.caps_lock);
        end
        expect_char(8'h41, "caps_A");
        expect_char(8'h71, "caps_shift_q");
        send_key(9'h158);
        send_key(9'h112);
        @(negedge clk);
        tests++;
        if (bus.caps_lock !== 1'b1) begin
            fails++;
            $display("FAIL caps_break_ignored: caps_lock=%b expected 1", bus.caps_lock);
        end
        send_key(9'h016);
        expect_char(8'h31, "caps_digit");
        send_key(9'h058);
        @(negedge clk);
        tests++;
        if (bus.caps_lock !== 1'b0) begin
            fails++;
            $display("FAIL caps_off: caps_lock=%b expected 0", bus.caps_lock);
        end
        expect_empty("caps_no_extra");
    endtask

    task automatic test_ctrl();
        send_key(9'h094);
        send_key(9'h021);
        send_key(9'h016);
        send_key(9'h194);
        send_key(9'h021);
        expect_char(8'h03, "ctrl_c");
        expect_char(8'h31, "ctrl_digit");
        expect_char(8'h63, "ctrl_released");
        send_key(9'h074);
        send_key(9'h09C);
        expect_empty("unmapped_and_ext");
    endtask

    task automatic test_full_push_pop();
        apply_reset();
        for (int i = 0; i < DEPTH; i++) begin
            @(posedge clk);
            #1;
            bus.key_code = {2'b00, letter_codes[i]};
            bus.kc_valid = 1'b1;
        end
        @(posedge clk);
        #1 bus.kc_valid = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (bus.fifo_count !== 4'(DEPTH) || bus.overflow !== 1'b0) begin
            fails++;
            $display("FAIL full_fill: count=%0d ovf=%b expected %0d 0", bus.fifo_count, bus.overflow, DEPTH);
        end
        @(posedge clk);
        #1;
        bus.key_code = 9'h042;
        bus.kc_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.kc_valid    = 1'b0;
        bus.ascii_ready = 1'b1;
        @(posedge clk);
        #1 bus.ascii_ready = 1'b0;
        @(negedge clk);
        tests++;
        if (bus.fifo_count !== 4'(DEPTH) || bus.overflow !== 1'b0 || bus.ascii_data !== 8'h62) begin
            fails++;
            $display("FAIL full_push_pop: count=%0d ovf=%b data=%h expected %0d 0 62",
                     bus.fifo_count, bus.overflow, bus.ascii_data, DEPTH);
        end
        for (int i = 1; i < DEPTH; i++) expect_char(8'h61 + 8'(i), "full_drain");
        expect_char(8'h6B, "full_drain_k");
        expect_empty("full_drain_empty");
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH + 2; i++) begin
            @(posedge clk);
            #1;
            bus.key_code = {2'b00, letter_codes[i]};
            bus.kc_valid = 1'b1;
        end
        @(posedge clk);
        #1 bus.kc_valid = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (bus.fifo_count !== 4'(DEPTH) || bus.overflow !== 1'b1) begin
            fails++;
            $display("FAIL overflow: count=%0d ovf=%b expected %0d 1", bus.fifo_count, bus.overflow, DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) expect_char(8'h61 + 8'(i), "ovf_drain");
        expect_empty("ovf_drain_empty");
        tests++;
        if (bus.overflow !== 1'b1) begin
            fails++;
            $display("FAIL overflow_sticky: ovf=%b expected 1", bus.overflow);
        end
    endtask

    task automatic test_reset_midstream();
        send_key(9'h01C);
        send_key(9'h032);
        @(posedge clk);
        #1;
        bus.key_code = 9'h021;
        bus.kc_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.kc_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        tests++;
        if (bus.fifo_count !== '0 || bus.ascii_valid !== 1'b0 || bus.overflow !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid: count=%0d valid=%b ovf=%b expected 0 0 0",
                     bus.fifo_count, bus.ascii_valid, bus.overflow);
        end
        expect_empty("reset_mid_inflight");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_shift_digits();
        test_caps();
        test_ctrl();
        test_full_push_pop();
        test_overflow();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ps2_ascii_decoder.md
# ps2_ascii_decoder

Consumes the 9-bit key codes from the PS/2 keyboard receiver and turns key presses into 8-bit ASCII characters for downstream consumers such as a UART, a console or a CPU register. It tracks modifier state (Shift, Ctrl, Caps Lock) and translates make codes through a fixed US-layout table. Characters are buffered in a small FIFO with a valid/ready output handshake, so a slow consumer never loses keystrokes unless the buffer overflows.

## Interface
- DEPTH, 8: FIFO depth in characters; power of two, 2..64.
- clk  in  1  system clock; the only clock domain.
- reset  in  1  synchronous, active-high reset.
- key_code  in  9  {released, extended, code[6:0]} from the PS/2 receiver.
- kc_valid  in  1  one-cycle strobe; key_code is valid in that cycle.
- ascii_data  out  8  character at the FIFO head; valid when ascii_valid=1.
- ascii_valid  out  1  FIFO not empty.
- ascii_ready  in  1  consumer accepts the head when ascii_valid & ascii_ready.
- fifo_count  out  $clog2(DEPTH)+1  occupancy.
- overflow  out  1  sticky; a character was dropped because the FIFO was full.
- caps_lock  out  1  current Caps Lock state (LED drive).

## Operation
- Modifiers are updated on every kc_valid:
  - lshift: code 0x12, non-extended. rshift: 0x59. lctrl: 0x14, non-extended. rctrl: 0x14, extended.
  - Each modifier is set on make (released=0) and cleared on break (released=1).
  - shift = lshift|rshift; ctrl = lctrl|rctrl.
- caps_lock toggles on make of 0x58 (non-extended). Breaks of 0x58 are ignored.
- Modifier and Caps Lock events produce no character.
- Breaks of all other keys produce no character.
- Extended keys other than rctrl produce no character.
- Translation applies to non-extended makes only. Table as code=lowercase:
  - Letters: 1C=a 32=b 21=c 23=d 24=e 2B=f 34=g 33=h 43=i 3B=j 42=k 4B=l 3A=m 31=n 44=o 4D=p 15=q 2D=r 1B=s 2C=t 3C=u 2A=v 1D=w 22=x 35=y 1A=z.
  - Digits: 45=0 16=1 1E=2 26=3 25=4 2E=5 36=6 3D=7 3E=8 46=9. Shifted forms: ) ! @ # $ % ^ & * (.
  - Others: 29=0x20 space, 5A=0x0D enter, 66=0x08 backspace, 0D=0x09 tab, 76=0x1B escape.
  - Unmapped codes are discarded silently.
- Case and control rules:
  - Letters: uppercase when shift XOR caps_lock.
  - Digits: shifted symbol when shift; caps_lock has no effect on digits.
  - ctrl with a letter outputs (uppercase letter & 0x1F), e.g. Ctrl+C = 0x03. ctrl has no effect on non-letters.
- Pipeline:
  - Stage 1 registers the translated character and a push flag.
  - Stage 2 writes the character to the FIFO.
  - Modifier state used for a key is the state before that key's own event is applied.
- FIFO rules:
  - Pop happens when ascii_valid & ascii_ready.
  - Push when full with a pop in the same cycle is accepted; count is unchanged.
  - Push when full without a pop is dropped and overflow is set.
  - Pointers wrap modulo DEPTH.

## Timing
- Reset values: ascii_valid=0, ascii_data=0x00, fifo_count=0, overflow=0, caps_lock=0. All modifiers clear; the pipeline push flag is clear.
- Reset asserted mid-stream empties the FIFO and discards the in-flight stage-1 character in the same edge.
- kc_valid in cycle N:
  - Stage 1 is valid in N+1.
  - The FIFO is written at the end of N+1.
  - ascii_valid=1 in N+2 if the FIFO was empty.
- ascii_data is registered from FIFO storage at the head. It changes only on pop or on a push into an empty FIFO.
- kc_valid may assert on consecutive cycles. Each event is processed with no stall, so throughput is 1 code/cycle.
- caps_lock and modifier registers update at the end of cycle N. They affect only later kc_valid events.
- ascii_ready may be held high permanently; back-to-back pops are allowed.
- overflow clears only on reset.

## Test plan
- Reset, then make 0x1C and break 0x11C -> exactly one char 0x61 appears, with ascii_valid high 2 cycles after the make kc_valid; break produces nothing.
- Make 0x12, make 0x1E, break 0x112, make 0x1E -> chars 0x40 then 0x32.
- Make 0x58, make 0x1C, make 0x12, make 0x15 -> caps_lock=1, chars 0x41 then 0x71 (shift cancels caps).
- Make extended rctrl 0x094, make 0x21 -> char 0x03. Extended make 0x074 alone -> no char.
- Hold ascii_ready=0, send DEPTH+2 letter makes -> fifo_count=DEPTH, overflow=1, and the first DEPTH chars drain in order once ready=1.
- Full FIFO, push and pop in the same cycle -> count stays DEPTH, overflow stays 0. Reset asserted during a push -> count 0, ascii_valid 0 the next cycle.
